// File: rtl/alu_stage_pkg.sv
// Shared types and constants for the ALU operand selection / ID-EX stage.
package alu_stage_pkg;

  // Width of the MOVZ immediate field.
  localparam int IMM16_W = 16;

  // Operand B source select.
  typedef enum logic [1:0] {
    SRC_RD2    = 2'd0,
    SRC_DADDR9 = 2'd1,
    SRC_IMM12  = 2'd2,
    SRC_MOVZ   = 2'd3
  } alusrc_e;

  // Forwarding source select; code 3 is not a distinct source.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_e;

  // Map a raw forwarding select onto a defined source; unused code 3 reads the register file.
  function automatic fwd_e fwd_decode(input logic [1:0] sel);
    fwd_e res;
    case (sel)
      2'd1:    res = FWD_EX;
      2'd2:    res = FWD_MEM;
      default: res = FWD_RF;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/operand_mux4.sv
// WIDTH-parametrised 4:1 operand multiplexer; every select code yields a defined input.
module operand_mux4 #(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);

  // Select one of four inputs, falling back to in0 for anything unexpected.
  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand selection (forwarding + immediate source) followed by a single
// ID/EX pipeline register with valid/ready handshake, stall and flush.
module alu_operand_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int IMM16_STEP = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   rd1,
  input  logic [WIDTH-1:0]   rd2,
  input  logic [WIDTH-1:0]   daddr9_ext,
  input  logic [WIDTH-1:0]   imm12_ext,
  input  logic [IMM16_W-1:0] imm16,
  input  logic [1:0]         hw,
  input  logic [1:0]         alusrc_sel,
  input  logic [1:0]         fwd_a_sel,
  input  logic [1:0]         fwd_b_sel,
  input  logic [WIDTH-1:0]   ex_result,
  input  logic [WIDTH-1:0]   mem_result,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   store_data
);

  fwd_e             fwd_a_s;
  fwd_e             fwd_b_s;
  alusrc_e          alusrc_s;
  logic [WIDTH-1:0] fa_s;
  logic [WIDTH-1:0] fb_s;
  logic [WIDTH-1:0] opb_next_s;
  logic [WIDTH-1:0] movz_s;
  logic [7:0]       movz_shamt_s;
  logic             load_s;
  logic             drain_s;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] op_a_d,      op_a_q;
  logic [WIDTH-1:0] op_b_d,      op_b_q;
  logic [WIDTH-1:0] store_d,     store_q;

  assign fwd_a_s  = fwd_decode(fwd_a_sel);
  assign fwd_b_s  = fwd_decode(fwd_b_sel);
  assign alusrc_s = alusrc_e'(alusrc_sel);

  // MOVZ: shift in a WIDTH-wide field so bits pushed past the top are dropped
  // (a shift of WIDTH or more yields zero).
  assign movz_shamt_s = 8'(int'(hw) * IMM16_STEP);
  assign movz_s       = WIDTH'(imm16) << movz_shamt_s;

  operand_mux4 #(.WIDTH(WIDTH)) u_fwd_a (
    .sel (fwd_a_s),
    .in0 (rd1),
    .in1 (ex_result),
    .in2 (mem_result),
    .in3 (rd1),
    .out (fa_s)
  );

  operand_mux4 #(.WIDTH(WIDTH)) u_fwd_b (
    .sel (fwd_b_s),
    .in0 (rd2),
    .in1 (ex_result),
    .in2 (mem_result),
    .in3 (rd2),
    .out (fb_s)
  );

  operand_mux4 #(.WIDTH(WIDTH)) u_alusrc (
    .sel (alusrc_s),
    .in0 (fb_s),
    .in1 (daddr9_ext),
    .in2 (imm12_ext),
    .in3 (movz_s),
    .out (opb_next_s)
  );

  // Single-entry register: ready whenever empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign load_s   = in_valid && in_ready;
  assign drain_s  = out_valid_q && out_ready && !load_s;

  // Next-state: data loads only on accept; flush overrides valid in every case.
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    store_d     = store_q;
    out_valid_d = out_valid_q;
    if (load_s) begin
      op_a_d  = fa_s;
      op_b_d  = opb_next_s;
      store_d = fb_s;
    end else begin
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      store_d = store_q;
    end
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_s) begin
      out_valid_d = 1'b1;
    end else if (drain_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline register; asynchronous reset discards any held entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      store_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      store_q     <= store_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign store_data = store_q;

endmodule
